// File: rtl/cmp_sar_search_pkg.sv
// Shared types and helpers for the SAR target search.
// State encoding, default width and the flag consistency check.
package cmp_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PROBE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Comparator flags are valid only when exactly one is set.
   function automatic logic onehot3(input logic a,
                                    input logic b,
                                    input logic c);
      return ({a, b, c} == 3'b100) ||
             ({a, b, c} == 3'b010) ||
             ({a, b, c} == 3'b001);
   endfunction

endpackage

// File: rtl/cmp_sar_bounds.sv
// Search window registers for the SAR target search.
// Produces the next midpoint and the window-exhausted flag.
module cmp_sar_bounds
   import cmp_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init,
   input  logic             upd_lo,
   input  logic             upd_hi,
   input  logic [WIDTH-1:0] guess,
   output logic [WIDTH-1:0] mid,
   output logic             exhausted
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH:0]   sum;

   // Next window and midpoint; the sum is one bit wider to avoid overflow.
   always_comb begin
      lo_d = lo_q;
      hi_d = hi_q;
      if (init) begin
         lo_d = '0;
         hi_d = '1;
      end else begin
         if (upd_lo) lo_d = guess + ONE;
         if (upd_hi) hi_d = guess - ONE;
      end
      sum       = {1'b0, lo_d} + {1'b0, hi_d};
      mid       = sum[WIDTH:1];
      exhausted = lo_d > hi_d;
   end

   // Window registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q <= '0;
         hi_q <= '1;
      end else begin
         lo_q <= lo_d;
         hi_q <= hi_d;
      end
   end

endmodule

// File: rtl/cmp_sar_search.sv
// Binary search for a hidden comparator target.
// Drives the probe, consumes G/L/E flags, reports via start/done.
module cmp_sar_search
   import cmp_pkg::*;
#(
   parameter  int WIDTH  = DEF_WIDTH,
   localparam int PCNT_W = $clog2(WIDTH + 2)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [WIDTH-1:0]  guess,
   input  logic              gt_in,
   input  logic              lt_in,
   input  logic              eq_in,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic              error,
   output logic [WIDTH-1:0]  result,
   output logic [PCNT_W-1:0] probes
);

   localparam logic [PCNT_W-1:0] P_ONE = PCNT_W'(1);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  guess_q, guess_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic [PCNT_W-1:0] probes_q, probes_d;
   logic              found_q, found_d;
   logic              error_q, error_d;

   logic             flags_ok;
   logic             init;
   logic             upd_lo;
   logic             upd_hi;
   logic [WIDTH-1:0] mid;
   logic             exhausted;

   assign flags_ok = onehot3(gt_in, lt_in, eq_in);
   assign init     = (state_q == ST_IDLE) && start;
   assign upd_lo   = (state_q == ST_PROBE) && flags_ok &&
                     gt_in && (guess_q != '1);
   assign upd_hi   = (state_q == ST_PROBE) && flags_ok &&
                     lt_in && (guess_q != '0);

   cmp_sar_bounds #(.WIDTH(WIDTH)) u_bounds (
      .clk       (clk),
      .rst_n     (rst_n),
      .init      (init),
      .upd_lo    (upd_lo),
      .upd_hi    (upd_hi),
      .guess     (guess_q),
      .mid       (mid),
      .exhausted (exhausted)
   );

   // Next-state and result bookkeeping for the search FSM.
   always_comb begin
      state_d  = state_q;
      guess_d  = guess_q;
      result_d = result_q;
      probes_d = probes_q;
      found_d  = found_q;
      error_d  = error_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               guess_d  = mid;
               result_d = '0;
               probes_d = '0;
               found_d  = 1'b0;
               error_d  = 1'b0;
               state_d  = ST_PROBE;
            end
         end
         ST_PROBE: begin
            probes_d = probes_q + P_ONE;
            state_d  = ST_DONE;
            if (!flags_ok) begin
               error_d = 1'b1;
               found_d = 1'b0;
            end else if (eq_in) begin
               result_d = guess_q;
               found_d  = 1'b1;
            end else if (upd_lo || upd_hi) begin
               if (!exhausted) begin
                  guess_d = mid;
                  state_d = ST_PROBE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Search state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         guess_q  <= '0;
         result_q <= '0;
         probes_q <= '0;
         found_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         guess_q  <= guess_d;
         result_q <= result_d;
         probes_q <= probes_d;
         found_q  <= found_d;
         error_q  <= error_d;
      end
   end

   assign guess  = guess_q;
   assign result = result_q;
   assign probes = probes_q;
   assign found  = found_q;
   assign error  = error_q;
   assign busy   = (state_q == ST_PROBE);
   assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_cmp_sar_search.sv
// Self-checking bench for cmp_sar_search.
// A behavioural comparator supplies the flags from a chosen target.
module tb_cmp_sar_search;

   localparam int W  = 4;
   localparam int PW = $clog2(W + 2);

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  guess;
   logic          gt_in;
   logic          lt_in;
   logic          eq_in;
   logic          busy;
   logic          done;
   logic          found;
   logic          error;
   logic [W-1:0]  result;
   logic [PW-1:0] probes;

   int target;
   bit force_err;
   int pass_cnt;
   int chk_cnt;

   cmp_sar_search #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .guess  (guess),
      .gt_in  (gt_in),
      .lt_in  (lt_in),
      .eq_in  (eq_in),
      .busy   (busy),
      .done   (done),
      .found  (found),
      .error  (error),
      .result (result),
      .probes (probes)
   );

   // Comparator stand-in; target 16 makes G stick high.
   assign gt_in = force_err ? 1'b1 : (target > int'(guess));
   assign lt_in = force_err ? 1'b1 : (target < int'(guess));
   assign eq_in = force_err ? 1'b0 : (target == int'(guess));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      #12;
      chk_cnt++;
      if ({busy, done, found, error} !== 4'b0 || guess !== '0 ||
          result !== '0 || probes !== '0) begin
         $display("FAIL reset: b%b d%b f%b e%b g%0d r%0d p%0d want zeros",
                  busy, done, found, error, guess, result, probes);
      end else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Runs one search and compares every observable to the model.
   task automatic run_search(input string nm, input int tgt,
                             input bit ferr, input bit repulse);
      int exp_g[$];
      int obs_g[$];
      int lo, hi, g, cyc, ep;
      bit ef, ee;
      int er;
      lo = 0;
      hi = 15;
      ef = 0;
      ee = 0;
      er = 0;
      if (ferr) begin
         exp_g.push_back(7);
         ee = 1;
      end else begin
         forever begin
            g = (lo + hi) / 2;
            exp_g.push_back(g);
            if (tgt == g) begin
               ef = 1;
               er = g;
               break;
            end else if (tgt > g) begin
               if (g == 15) break;
               lo = g + 1;
            end else begin
               if (g == 0) break;
               hi = g - 1;
            end
            if (lo > hi) break;
         end
      end
      ep = exp_g.size();
      target = tgt;
      force_err = ferr;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 20) begin
         if (busy) obs_g.push_back(int'(guess));
         start = (repulse && cyc == 2);
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b0;
      chk_cnt++;
      if (!done) $display("FAIL %s timeout: no done within %0d", nm, cyc);
      else pass_cnt++;
      chk_cnt++;
      if (obs_g.size() !== ep) begin
         $display("FAIL %s nprobe_guesses: got %0d want %0d",
                  nm, obs_g.size(), ep);
      end else pass_cnt++;
      for (int i = 0; i < ep && i < obs_g.size(); i++) begin
         chk_cnt++;
         if (obs_g[i] !== exp_g[i]) begin
            $display("FAIL %s guess[%0d]: got %0d want %0d",
                     nm, i, obs_g[i], exp_g[i]);
         end else pass_cnt++;
      end
      chk_cnt++;
      if (int'(probes) !== ep || found !== ef || error !== ee ||
          int'(result) !== er || busy !== 1'b0) begin
         $display("FAIL %s outputs: p%0d f%b e%b r%0d b%b want p%0d f%b e%b r%0d b0",
                  nm, probes, found, error, result, busy, ep, ef, ee, er);
      end else pass_cnt++;
      chk_cnt++;
      if (cyc !== ep + 1) begin
         $display("FAIL %s latency: got %0d want %0d", nm, cyc, ep + 1);
      end else pass_cnt++;
      force_err = 1'b0;
      target = 3;
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++;
      if (done !== 1'b0 || busy !== 1'b0 || int'(probes) !== ep ||
          found !== ef || error !== ee || int'(result) !== er) begin
         $display("FAIL %s hold: d%b b%b p%0d f%b e%b r%0d want d0 b0 p%0d f%b e%b r%0d",
                  nm, done, busy, probes, found, error, result, ep, ef, ee, er);
      end else pass_cnt++;
   endtask

   task automatic test_directed();
      run_search("p7", 7, 0, 0);
      run_search("p0", 0, 0, 0);
      run_search("p15", 15, 0, 0);
      run_search("p10", 10, 0, 0);
   endtask

   task automatic test_no_wrap();
      run_search("gt_stuck", 16, 0, 0);
   endtask

   task automatic test_bad_flags();
      run_search("bad_flags", 5, 1, 0);
   endtask

   task automatic test_restart_ignored();
      run_search("repulse", 10, 0, 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         run_search("rand", int'($urandom_range(0, 15)), 0, 0);
      end
   endtask

   task automatic test_abort();
      bit saw_done;
      target = 0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk_cnt++;
      if (busy !== 1'b1 || probes !== PW'(2)) begin
         $display("FAIL abort_pre: b%b p%0d want b1 p2", busy, probes);
      end else pass_cnt++;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({busy, done, found, error} !== 4'b0 || guess !== '0 ||
          result !== '0 || probes !== '0) begin
         $display("FAIL abort_reset: b%b d%b f%b e%b g%0d r%0d p%0d want zeros",
                  busy, done, found, error, guess, result, probes);
      end else pass_cnt++;
      saw_done = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1;
      end
      chk_cnt++;
      if (saw_done !== 1'b0) $display("FAIL abort_done: got 1 want 0");
      else pass_cnt++;
      run_search("post_abort", 12, 0, 0);
   endtask

   initial begin
      pass_cnt = 0;
      chk_cnt = 0;
      target = 3;
      force_err = 1'b0;
      test_reset();
      test_directed();
      test_no_wrap();
      test_bad_flags();
      test_restart_ignored();
      test_abort();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/cmp_sar_search.md
Name: cmp_sar_search

Overview:
- Sequential counterpart to the team's combinational magnitude comparator.
- The comparator takes a hidden target P and a probe Q and returns greater/less/equal flags. This block drives Q and consumes those flags.
- It binary-searches for the target value and reports it with a start/done handshake.
- It sits beside a comparator instance: the guess port drives the comparator's Q input, and the G/L/E outputs feed back into gt_in/lt_in/eq_in.

Parameters:
- WIDTH, 4, bit width of target, guess and result.
- PCNT_W, $clog2(WIDTH+2), localparam, width of the probe counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a search; sampled only in IDLE.
- guess  output  WIDTH  registered probe value driven to the comparator Q input.
- gt_in  input  1  comparator G: target > guess.
- lt_in  input  1  comparator L: target < guess.
- eq_in  input  1  comparator E: target == guess.
- busy  output  1  high while probing.
- done  output  1  one-cycle pulse when a search ends.
- found  output  1  target located; held until the next start.
- error  output  1  flags were inconsistent; held until the next start.
- result  output  WIDTH  located value; held until the next start.
- probes  output  PCNT_W  number of comparator samples used in the last search.

Behaviour:
- Reset (async assert, sync release): state=IDLE; guess, result, probes, lo=0; hi=all-ones; busy, done, found, error all 0.
- States: IDLE, PROBE, DONE.
- IDLE with start=1:
  - lo=0, hi=2^WIDTH-1.
  - guess=(lo+hi)>>1, computed at WIDTH+1 bits (7 for WIDTH=4).
  - probes=0; clear found, error and result.
  - Go to PROBE, busy=1.
- IDLE with start=0: hold all outputs.
- PROBE:
  - The comparator is combinational, so the flags are sampled at each edge in PROBE for the guess registered on the previous edge.
  - Each edge: probes+=1, then evaluate:
    - Exactly one flag must be high. Otherwise error=1, found=0, go to DONE.
    - eq_in: result=guess, found=1, go to DONE.
    - gt_in with guess==all-ones: found=0, go to DONE (no wrap). Otherwise lo=guess+1.
    - lt_in with guess==0: found=0, go to DONE (no underflow). Otherwise hi=guess-1.
    - After a bound update, if lo>hi: found=0, go to DONE. Otherwise guess=(lo+hi)>>1 and stay in PROBE.
  - Maximum probes is WIDTH+1, which bounds the search.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - result, found, error, probes and guess hold until the next accepted start.
- start while in PROBE or DONE is ignored. No queuing.
- rst_n low mid-search aborts immediately to reset values. No done pulse is emitted.
- Latency from the accepted start edge to done high is probes+1 cycles.
- All arithmetic is unsigned. The lo/hi sum uses a WIDTH+1-bit intermediate.

Decomposition:
- Shared package cmp_pkg holds:
  - the state enum localparams (ST_IDLE, ST_PROBE, ST_DONE);
  - default WIDTH;
  - the flag-consistency check as a function (onehot3).
- One sub-module is natural: cmp_sar_bounds. It holds the lo/hi registers and computes next lo/hi/mid and the lo>hi exhaustion flag.
- The FSM, counter and outputs stay in the top level.
- The bench instantiates the existing comparator as the flag source.

Test Plan:
- Target P=7, pulse start: guess=7, eq on the first sample. Expect done 2 cycles after start, found=1, result=7, probes=1.
- Target P=0: guess sequence 7,3,1,0. Expect found=1, result=0, probes=4, no underflow.
- Target P=15: guess sequence 7,11,13,14,15. Expect found=1, result=15, probes=5. Also run P=10: guesses 7,11,9,10, probes=4.
- Bench forces gt_in=1 always (eq never asserted): guesses 7,11,13,14,15, then gt at all-ones. Expect found=0, error=0, probes=5, no wrap to 0.
- Force gt_in=lt_in=1 on the first sample. Expect error=1, found=0, probes=1, done pulse.
- Start re-pulsed during PROBE is ignored and the guess sequence is unchanged. Separately, rst_n low after 2 probes: all outputs at reset values immediately and no done pulse. A new start then searches normally.
